// File: rtl/hack_data_mem.sv
// Hack data memory: 16K-word RAM, 8K-word screen, keyboard FIFO and a registered video read port.
// Optional macro HACK_MEM_ERR_EN adds a sticky bus_err output for writes to KSTAT or unmapped space.
module hack_data_mem #(
  parameter int N         = 16,
  parameter int KBD_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] addRAM,
  input  logic [N-1:0] inRAM,
  input  logic         enM,
  output logic [N-1:0] outRAM,
  input  logic         kbd_valid,
  input  logic [N-1:0] kbd_data,
  output logic         kbd_ready,
  input  logic [12:0]  vid_addr,
  output logic [N-1:0] vid_data
`ifdef HACK_MEM_ERR_EN
  ,
  output logic         bus_err
`endif
);

  localparam int PW = $clog2(KBD_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(KBD_DEPTH);

  logic [N-1:0] ram_mem  [16384];
  logic [N-1:0] scr_mem  [8192];
  logic [N-1:0] fifo_mem [KBD_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [N-1:0]  vid_data_q, vid_data_d;

  logic sel_ram, sel_scr, sel_kbd, sel_kst, sel_bad;
  logic push, pop;
  logic [N-1:0] kbd_head;

  // Map decode assumes a 16-bit address; bit 15 set is always unmapped.
  always_comb begin
    sel_ram = (addRAM[15:14] == 2'b00);
    sel_scr = (addRAM[15:13] == 3'b010);
    sel_kbd = (addRAM[15:0] == 16'h6000);
    sel_kst = (addRAM[15:0] == 16'h6001);
    sel_bad = ~(sel_ram | sel_scr | sel_kbd | sel_kst);
  end

  assign kbd_ready = (count_q != DEPTH_C);
  assign push      = kbd_valid & kbd_ready & (kbd_data != '0) & ~rst;
  assign pop       = enM & sel_kbd & (count_q != '0) & ~rst;
  assign kbd_head  = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;

  always_comb begin
    outRAM = '0;
    if (sel_ram)      outRAM = ram_mem[addRAM[13:0]];
    else if (sel_scr) outRAM = scr_mem[addRAM[12:0]];
    else if (sel_kbd) outRAM = kbd_head;
    else if (sel_kst) outRAM = N'(count_q);
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    vid_data_d = scr_mem[vid_addr];
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      vid_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      vid_data_q <= vid_data_d;
    end
  end

  // Storage arrays carry no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (enM & sel_ram) ram_mem[addRAM[13:0]] <= inRAM;
    if (enM & sel_scr) scr_mem[addRAM[12:0]] <= inRAM;
    if (push)          fifo_mem[wr_ptr_q]    <= kbd_data;
  end

  assign vid_data = vid_data_q;

`ifdef HACK_MEM_ERR_EN
  logic bus_err_q, bus_err_d;

  assign bus_err_d = bus_err_q | (enM & (sel_kst | sel_bad));

  always_ff @(posedge clk) begin
    if (rst) bus_err_q <= 1'b0;
    else     bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_hack_data_mem.sv
// Self-checking bench for hack_data_mem: scoreboard of expected read/video results plus a FIFO model.
// Build with +define+HACK_MEM_ERR_EN to also exercise bus_err.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addRAM, inRAM, outRAM, kbd_data, vid_data;
  logic        enM, kbd_valid, kbd_ready;
  logic [12:0] vid_addr;
`ifdef HACK_MEM_ERR_EN
  logic        bus_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] kbd_model[$];

  hack_data_mem #(.N(16), .KBD_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addRAM(addRAM), .inRAM(inRAM), .enM(enM), .outRAM(outRAM),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .vid_addr(vid_addr), .vid_data(vid_data)
`ifdef HACK_MEM_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [15:0] got);
    string t;
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, got, e);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    addRAM = a; enM = 1'b0;
    sb_push(tag, exp);
    #2 sb_pop(outRAM);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addRAM = a; inRAM = d; enM = 1'b1;
    @(negedge clk);
    enM = 1'b0;
  endtask

  task automatic pop_key();
    wr(16'h6000, 16'h0);
    if (kbd_model.size() > 0) void'(kbd_model.pop_front());
  endtask

  task automatic push_key(input logic [15:0] code);
    @(negedge clk);
    kbd_valid = 1'b1; kbd_data = code;
    if (code != 16'h0 && kbd_model.size() < 8) kbd_model.push_back(code);
    @(negedge clk);
    kbd_valid = 1'b0;
  endtask

  function automatic logic [15:0] model_head();
    return (kbd_model.size() > 0) ? kbd_model[0] : 16'h0;
  endfunction

  task automatic chk_fifo(input string tag);
    rd({tag, "_kbd"},   16'h6000, model_head());
    rd({tag, "_kstat"}, 16'h6001, 16'(kbd_model.size()));
  endtask

  initial begin
    rst = 1'b1; addRAM = '0; inRAM = '0; enM = 1'b0;
    kbd_valid = 1'b0; kbd_data = '0; vid_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", {15'b0, kbd_ready}, 16'd1);
    chk("reset_vid", vid_data, 16'h0);
    chk_fifo("reset");
`ifdef HACK_MEM_ERR_EN
    chk("reset_buserr", {15'b0, bus_err}, 16'd0);
`endif

    wr(16'h0005, 16'h1234);
    rd("ram_0005", 16'h0005, 16'h1234);
    wr(16'h4010, 16'hBEEF);
    @(negedge clk);
    vid_addr = 13'h010;
    sb_push("vid_0010", 16'hBEEF);
    @(negedge clk);
    sb_pop(vid_data);
    wr(16'h5FFF, 16'h00FF);
    rd("scr_5fff", 16'h5FFF, 16'h00FF);
    wr(16'h0000, 16'h0A0A);
    rd("ram_0000", 16'h0000, 16'h0A0A);
    rd("ram_0005_kept", 16'h0005, 16'h1234);

    // Read-during-write: old value this cycle, new value next cycle.
    @(negedge clk);
    addRAM = 16'h0005; inRAM = 16'h5555; enM = 1'b1;
    #2 chk("rdw_old", outRAM, 16'h1234);
    @(negedge clk);
    enM = 1'b0;
    #2 chk("rdw_new", outRAM, 16'h5555);

    push_key(16'h0041);
    push_key(16'h0042);
    chk_fifo("two_keys");
    pop_key();
    chk_fifo("pop1");
    pop_key();
    chk_fifo("pop2");
    pop_key();
    chk_fifo("pop_empty");

    for (int i = 0; i < 8; i++) push_key(16'h0061 + 16'(i));
    @(negedge clk);
    chk("full_ready", {15'b0, kbd_ready}, 16'd0);
    chk_fifo("full");
    // Hold 0x69 while full; a pop this cycle lets it in the following cycle.
    kbd_valid = 1'b1; kbd_data = 16'h0069;
    addRAM = 16'h6000; enM = 1'b1;
    #2 chk("full_pop_ready", {15'b0, kbd_ready}, 16'd0);
    void'(kbd_model.pop_front());
    @(negedge clk);
    enM = 1'b0;
    #1 chk("after_pop_ready", {15'b0, kbd_ready}, 16'd1);
    kbd_model.push_back(16'h0069);
    @(negedge clk);
    kbd_valid = 1'b0;
    chk_fifo("refull");
    for (int i = 0; i < 8; i++) begin
      rd("drain_order", 16'h6000, 16'h0062 + 16'(i));
      pop_key();
    end
    chk_fifo("drained");

    push_key(16'h0010);
    push_key(16'h0011);
    push_key(16'h0012);
    @(negedge clk);
    kbd_valid = 1'b1; kbd_data = 16'h0013;
    addRAM = 16'h6000; enM = 1'b1;
    void'(kbd_model.pop_front());
    kbd_model.push_back(16'h0013);
    @(negedge clk);
    kbd_valid = 1'b0; enM = 1'b0;
    chk_fifo("push_pop");
    push_key(16'h0000);
    chk_fifo("zero_code");

    wr(16'h0002, 16'hAAAA);
    rd("unmap_6002", 16'h6002, 16'h0);
    rd("unmap_8000", 16'h8000, 16'h0);
    rd("unmap_ffff", 16'hFFFF, 16'h0);
`ifdef HACK_MEM_ERR_EN
    chk("buserr_pre", {15'b0, bus_err}, 16'd0);
`endif
    wr(16'h6002, 16'h1111);
`ifdef HACK_MEM_ERR_EN
    chk("buserr_set", {15'b0, bus_err}, 16'd1);
`endif
    wr(16'h8002, 16'h2222);
    wr(16'hC002, 16'h3333);
    wr(16'h6001, 16'h0007);
    rd("ram_0002_kept", 16'h0002, 16'hAAAA);
    chk_fifo("after_unmapped");
`ifdef HACK_MEM_ERR_EN
    repeat (3) @(negedge clk);
    chk("buserr_sticky", {15'b0, bus_err}, 16'd1);
`endif

    push_key(16'h0020);
    push_key(16'h0021);
    chk_fifo("five_queued");
    @(negedge clk);
    vid_addr = 13'h010;
    @(negedge clk);
    chk("vid_before_rst", vid_data, 16'hBEEF);
    rst = 1'b1;
    kbd_valid = 1'b1; kbd_data = 16'h0077;
    addRAM = 16'h6000; enM = 1'b1;
    @(negedge clk);
    rst = 1'b0; kbd_valid = 1'b0; enM = 1'b0;
    kbd_model.delete();
    addRAM = 16'h6001;
    #1 chk("rst_kstat", outRAM, 16'h0);
    addRAM = 16'h6000;
    #1 chk("rst_kbd", outRAM, 16'h0);
    chk("rst_ready", {15'b0, kbd_ready}, 16'd1);
    chk("rst_vid", vid_data, 16'h0);
`ifdef HACK_MEM_ERR_EN
    chk("rst_buserr", {15'b0, bus_err}, 16'd0);
`endif
    chk_fifo("post_rst");
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
